pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port stall, input, 1, hazard stall that holds the PC.
REQ-005 SHALL have port redirect, input, 1, taken branch/jump qualifier.
REQ-006 SHALL have port redirect_pc, input, 16, branch/jump target address.
REQ-007 SHALL have port halt, input, 1, HALT instruction decoded.
REQ-008 SHALL have port imem_ready, input, 1, instruction memory accepts the current fetch address.
REQ-009 SHALL have port pc, output, 16, current fetch address.
REQ-010 SHALL have port pc_plus2, output, 16, combinational pc + 2 for the link register and sequential path.
REQ-011 SHALL have port fetch_valid, output, 1, the fetch request on pc is valid.
REQ-012 SHALL have port halted, output, 1, the block is in HALTED.
REQ-013 SHALL have port misalign_err, output, 1, sticky flag for an odd redirect target.
REQ-014 SHALL have port fetch_count, output, 16, number of accepted fetches.

Function
REQ-015 SHALL implement states BOOT, RUN and HALTED, with BOOT as the reset state.
REQ-016 SHALL move BOOT -> RUN unconditionally one cycle after reset release, with fetch_valid=0 and pc=RESET_PC in BOOT.
REQ-017 SHALL drive fetch_valid=1 only in RUN.
REQ-018 SHALL define accept = RUN & imem_ready & ~stall.
REQ-019 SHALL, in RUN, give the next-PC priority redirect > (stall | ~imem_ready) hold > accept advance to pc_plus2.
REQ-020 SHALL apply redirect even when stall=1 or imem_ready=0; the target appears on pc the next cycle.
REQ-021 SHALL load {redirect_pc[15:1],1'b0} on a redirect with redirect_pc[0]=1, and set misalign_err, which stays set until reset.
REQ-022 SHALL compute pc_plus2 = (pc + 2) mod 2^16, so 16'hFFFE wraps to 16'h0000 with no carry out and no error.
REQ-023 SHALL keep pc[0]=0 at all times.
REQ-024 SHALL, on halt in RUN, go to HALTED the next cycle; pc holds unless redirect is asserted in the same cycle, in which case pc loads the target.
REQ-025 SHALL count a fetch accepted in the same cycle as halt, when accept is true.
REQ-026 SHALL keep HALTED terminal until reset: all inputs ignored, pc and fetch_count frozen, fetch_valid=0, halted=1.
REQ-027 SHALL increment fetch_count by 1 on each accept, saturating at 16'hFFFF.
REQ-028 SHALL increment fetch_count on accept even when redirect is asserted in the same cycle.
REQ-029 SHALL ignore stall, redirect, halt and imem_ready in BOOT.

Reset
REQ-030 SHALL, on rst_n=0 and independent of clk, immediately force state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0, misalign_err=0, fetch_count=0.
REQ-031 SHALL make pc_plus2 = RESET_PC + 2 during reset.
REQ-032 SHALL abandon any redirect, halt or stall in progress when rst_n asserts mid-operation.
REQ-033 SHALL resume with a BOOT cycle after rst_n deasserts.

Verification
REQ-034 SHALL cover: reset, then imem_ready=1, stall=0 for 4 cycles -> pc = 0,0,2,4,6 (BOOT cycle first), fetch_count=3, fetch_valid 0->1 after BOOT.
REQ-035 SHALL cover: in RUN at pc=0x0010, stall=1 and redirect=1 with redirect_pc=0x0100 -> next pc=0x0100, fetch_count unchanged.
REQ-036 SHALL cover: redirect_pc=0x0201 -> pc=0x0200, misalign_err=1, which stays 1 through later normal fetches until rst_n=0.
REQ-037 SHALL cover: redirect to 0xFFFE, then one accept -> pc=0x0000, pc_plus2=0x0002, no error.
REQ-038 SHALL cover: halt=1 with accept at pc=0x0040 -> pc=0x0040 held, halted=1, count incremented once, then frozen despite redirect/stall toggling.
REQ-039 SHALL cover: rst_n pulsed low mid-cycle while HALTED -> outputs reset asynchronously before the next clk edge, BOOT then RUN resume.

Source files
------------

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and fetch request generator with BOOT/RUN/HALTED control
module pc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        fetch_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Bit 0 of the PC is forced low so an odd RESET_PC can never produce an odd fetch address.
  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] count_q, count_d;
  logic        misalign_q, misalign_d;
  logic        accept;

  assign pc           = pc_q;
  assign pc_plus2     = pc_q + 16'd2;
  assign fetch_valid  = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALTED);
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;
  assign accept       = (state_q == ST_RUN) & imem_ready & ~stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Counting is independent of where the PC goes, so a redirecting or halting fetch still counts.
        if (accept && (count_q != 16'hFFFF)) begin
          count_d = count_q + 16'd1;
        end
        if (redirect) begin
          pc_d = {redirect_pc[15:1], 1'b0};
          if (redirect_pc[0]) begin
            misalign_d = 1'b1;
          end
        end else if (accept && !halt) begin
          pc_d = pc_plus2;
        end
        if (halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC_ALIGNED;
      count_q    <= 16'h0000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed and randomized bench for pc_fetch against a behavioural model
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_ready;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_valid;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0=boot, 1=run, 2=halted; pc and count as plain integers.
  int m_mode;
  int m_pc;
  int m_cnt;
  int m_mis;

  pc_fetch #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .fetch_valid  (fetch_valid),
    .halted       (halted),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       pc,                      16'(m_pc));
    chk({tag, ".pc_plus2"}, pc_plus2,                16'((m_pc + 2) % 65536));
    chk({tag, ".valid"},    {15'd0, fetch_valid},    (m_mode == 1) ? 16'd1 : 16'd0);
    chk({tag, ".halted"},   {15'd0, halted},         (m_mode == 2) ? 16'd1 : 16'd0);
    chk({tag, ".misalign"}, {15'd0, misalign_err},   16'(m_mis));
    chk({tag, ".count"},    fetch_count,             16'(m_cnt));
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    m_mis  = 0;
  endtask

  task automatic model_edge(input bit st, input bit rd, input int rpc, input bit hl, input bit rdy);
    bit acc;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      acc = rdy && !st;
      if (acc && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (rd) begin
        m_pc = rpc - (rpc % 2);
        if (rpc % 2 == 1) m_mis = 1;
      end else if (acc && !hl) begin
        m_pc = (m_pc + 2) % 65536;
      end
      if (hl) m_mode = 2;
    end
  endtask

  task automatic step(input string tag, input bit st, input bit rd, input int rpc, input bit hl, input bit rdy);
    stall       = st;
    redirect    = rd;
    redirect_pc = 16'(rpc);
    halt        = hl;
    imem_ready  = rdy;
    @(posedge clk);
    model_edge(st, rd, rpc, hl, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    imem_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all({tag, ".in_reset"});
    rst_n = 1'b1;
    check_all({tag, ".boot"});
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    imem_ready  = 1'b0;
    model_reset();

    // Boot then four sequential fetches: 0,0,2,4,6
    do_reset("r0");
    for (int i = 0; i < 4; i++) step("seq", 0, 0, 0, 0, 1);
    chk("seq.final_pc", pc, 16'h0006);
    chk("seq.final_cnt", fetch_count, 16'd3);

    // Redirect under stall does not count
    step("to10", 1, 1, 16'h0010, 0, 1);
    step("stall_redir", 1, 1, 16'h0100, 0, 1);
    chk("stall_redir.pc", pc, 16'h0100);
    chk("stall_redir.cnt", fetch_count, 16'd3);
    step("redir_notready", 0, 1, 16'h0120, 0, 0);

    // Odd target is aligned and sticks the error flag
    step("odd", 0, 1, 16'h0201, 0, 1);
    chk("odd.pc", pc, 16'h0200);
    chk("odd.mis", {15'd0, misalign_err}, 16'd1);
    for (int i = 0; i < 3; i++) step("odd_after", 0, 0, 0, 0, 1);

    // Wrap at the top of the address space
    do_reset("r1");
    step("boot_ignored", 1, 1, 16'h1235, 1, 0);
    step("to_fffe", 0, 1, 16'hFFFE, 0, 1);
    step("wrap", 0, 0, 0, 0, 1);
    chk("wrap.pc", pc, 16'h0000);
    chk("wrap.pc_plus2", pc_plus2, 16'h0002);
    chk("wrap.mis", {15'd0, misalign_err}, 16'd0);

    // Halt with accept at 0x0040, then frozen
    step("to40", 0, 1, 16'h0040, 0, 0);
    step("halt", 0, 0, 0, 1, 1);
    chk("halt.pc", pc, 16'h0040);
    chk("halt.halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 6; i++) step("frozen", i[0], ~i[0], 16'h0801 + i, i[1], 1);

    // Asynchronous reset mid-cycle while halted
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async");
    @(negedge clk);
    rst_n = 1'b1;
    check_all("async.boot");
    step("async.run", 0, 0, 0, 0, 1);

    // Halt together with redirect loads the target
    step("halt_redir", 1, 1, 16'h0333, 1, 1);
    chk("halt_redir.pc", pc, 16'h0332);
    do_reset("r2");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom % 4) == 0,
           ($urandom % 6) == 0,
           int'($urandom % 65536),
           ($urandom % 40) == 0,
           ($urandom % 4) != 0);
      if (m_mode == 2) begin
        step("rand_frozen", 0, 1, 16'h0500, 0, 1);
        do_reset("rand_r");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
